// File: rtl/can_tx_scheduler.sv
// CAN transmit mailbox scheduler: holds NUM_MB frames, launches the lowest
// ID first, and sequences the TX engine through launch, frame and IFS.
// Ports:
//   clk, rst (async, active-low), baud_tick (one pulse per CAN bit)
//   mb_wr/mb_wr_id/mb_wr_data : mailbox load; mb_abort : cancel per mailbox
//   tx_active/frame_done/arb_lost : TX engine status
//   tx_send/tx_address/tx_data/cur_mb : launch request and selected frame
//   mb_pending : unsent frames; mb_done/mb_fail/wr_err : one-clk pulses
//   busy : scheduler not idle
module can_tx_scheduler #(
    parameter int NUM_MB        = 4,
    parameter int RETRY_MAX     = 7,
    parameter int IFS_BITS      = 3,
    parameter int START_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [NUM_MB-1:0] mb_wr,
    input  logic [10:0]       mb_wr_id,
    input  logic [63:0]       mb_wr_data,
    input  logic [NUM_MB-1:0] mb_abort,
    input  logic              tx_active,
    input  logic              frame_done,
    input  logic              arb_lost,
    output logic              tx_send,
    output logic [10:0]       tx_address,
    output logic [63:0]       tx_data,
    output logic [2:0]        cur_mb,
    output logic [NUM_MB-1:0] mb_pending,
    output logic [NUM_MB-1:0] mb_done,
    output logic [NUM_MB-1:0] mb_fail,
    output logic              wr_err,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_LAUNCH, S_BUSY, S_IFS
    } state_t;

    localparam logic [7:0] TO_LAST  = 8'(START_TIMEOUT - 1);
    localparam logic [7:0] IFS_LAST = 8'(IFS_BITS - 1);
    localparam logic [3:0] RMAX4    = 4'(RETRY_MAX);

    state_t state, state_nxt;

    logic [10:0] id_q    [NUM_MB];
    logic [63:0] data_q  [NUM_MB];
    logic [3:0]  retry_q [NUM_MB];
    logic [7:0]  cnt;
    logic        abort_lat;

    logic              cnt_clr, cnt_inc;
    logic              fin_done, fin_fail, fin_retry;
    logic              in_flight, abort_eff;
    logic [NUM_MB-1:0] cur_oh, elig;
    logic              sel_ok;
    logic [2:0]        sel_idx;
    logic [10:0]       sel_id;
    logic [63:0]       sel_data;

    assign tx_send   = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);
    assign in_flight = (state == S_LAUNCH) || (state == S_BUSY);
    assign abort_eff = abort_lat || |(mb_abort & cur_oh);

    // Mailboxes being written or aborted this cycle sit out the selection;
    // if nothing is left the FSM drops back to IDLE and re-evaluates.
    always_comb begin
        elig     = mb_pending & ~mb_abort & ~mb_wr;
        sel_ok   = 1'b0;
        sel_idx  = '0;
        sel_id   = '1;
        sel_data = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (elig[i] && (!sel_ok || id_q[i] < sel_id)) begin
                sel_ok   = 1'b1;
                sel_idx  = 3'(i);
                sel_id   = id_q[i];
                sel_data = data_q[i];
            end
        end
    end

    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_MB; i++)
            cur_oh[i] = in_flight && (cur_mb == 3'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        fin_done  = 1'b0;
        fin_fail  = 1'b0;
        fin_retry = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|mb_pending && !tx_active)
                    state_nxt = S_SELECT;
            end
            S_SELECT: begin
                cnt_clr   = 1'b1;
                state_nxt = sel_ok ? S_LAUNCH : S_IDLE;
            end
            S_LAUNCH: begin
                if (tx_active) begin
                    state_nxt = S_BUSY;
                end else if (baud_tick) begin
                    if (cnt == TO_LAST) begin
                        fin_fail  = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = S_IFS;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                cnt_clr = 1'b1;
                if (frame_done) begin
                    fin_done  = 1'b1;
                    state_nxt = S_IFS;
                end else if (arb_lost) begin
                    fin_retry = 1'b1;
                    state_nxt = S_IFS;
                end
            end
            S_IFS: begin
                // spacing only counts once the bus is released
                if (tx_active) begin
                    cnt_clr = 1'b1;
                end else if (baud_tick) begin
                    if (cnt == IFS_LAST) state_nxt = S_IDLE;
                    else                 cnt_inc   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_address <= '0;
            tx_data    <= '0;
            cur_mb     <= '0;
            mb_pending <= '0;
            mb_done    <= '0;
            mb_fail    <= '0;
            wr_err     <= 1'b0;
            cnt        <= '0;
            abort_lat  <= 1'b0;
            for (int i = 0; i < NUM_MB; i++) begin
                id_q[i]    <= '0;
                data_q[i]  <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            mb_done <= '0;
            mb_fail <= '0;
            wr_err  <= 1'b0;

            if (state == S_SELECT && sel_ok) begin
                tx_address <= sel_id;
                tx_data    <= sel_data;
                cur_mb     <= sel_idx;
            end

            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 8'd1;

            if (state == S_SELECT)      abort_lat <= 1'b0;
            else if (|(mb_abort & cur_oh)) abort_lat <= 1'b1;

            for (int i = 0; i < NUM_MB; i++) begin
                if (mb_abort[i]) begin
                    if (mb_wr[i]) wr_err <= 1'b1;
                    if (!cur_oh[i]) begin
                        mb_pending[i] <= 1'b0;
                        mb_fail[i]    <= mb_pending[i];
                    end
                end else if (mb_wr[i]) begin
                    if (cur_oh[i]) begin
                        wr_err <= 1'b1;
                    end else begin
                        id_q[i]       <= mb_wr_id;
                        data_q[i]     <= mb_wr_data;
                        mb_pending[i] <= 1'b1;
                        retry_q[i]    <= '0;
                    end
                end
                if (cur_oh[i]) begin
                    if (fin_done) begin
                        mb_pending[i] <= 1'b0;
                        mb_done[i]    <= 1'b1;
                    end
                    if (fin_fail) begin
                        mb_pending[i] <= 1'b0;
                        mb_fail[i]    <= 1'b1;
                    end
                    if (fin_retry) begin
                        if (retry_q[i] != 4'hF)
                            retry_q[i] <= retry_q[i] + 4'd1;
                        if (abort_eff || (retry_q[i] + 4'd1) == RMAX4) begin
                            mb_pending[i] <= 1'b0;
                            mb_fail[i]    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Bench for can_tx_scheduler: mailbox-level reference model plus directed
// scenarios emulating the TX engine.
module tb_can_tx_scheduler;

    localparam int NMB  = 4;
    localparam int RMAX = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        baud_tick = 1'b0;
    logic [3:0]  mb_wr = '0;
    logic [10:0] mb_wr_id = '0;
    logic [63:0] mb_wr_data = '0;
    logic [3:0]  mb_abort = '0;
    logic        tx_active = 1'b0;
    logic        frame_done = 1'b0;
    logic        arb_lost = 1'b0;
    logic        tx_send;
    logic [10:0] tx_address;
    logic [63:0] tx_data;
    logic [2:0]  cur_mb;
    logic [3:0]  mb_pending, mb_done, mb_fail;
    logic        wr_err, busy;

    always #5 clk = ~clk;

    can_tx_scheduler #(
        .NUM_MB(NMB), .RETRY_MAX(RMAX), .IFS_BITS(3), .START_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .mb_wr(mb_wr), .mb_wr_id(mb_wr_id), .mb_wr_data(mb_wr_data),
        .mb_abort(mb_abort), .tx_active(tx_active),
        .frame_done(frame_done), .arb_lost(arb_lost),
        .tx_send(tx_send), .tx_address(tx_address), .tx_data(tx_data),
        .cur_mb(cur_mb), .mb_pending(mb_pending), .mb_done(mb_done),
        .mb_fail(mb_fail), .wr_err(wr_err), .busy(busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: mailbox contents and outcome pulses.
    logic [3:0]  m_pend;
    logic [10:0] m_id   [NMB];
    logic [63:0] m_data [NMB];
    int          m_retry[NMB];
    logic [3:0]  exp_done, exp_fail;
    logic        exp_werr;
    bit          fl_v, lat, act_prev, m_to;
    int          fl;

    function automatic int pick();
        int p = -1;
        for (int i = 0; i < NMB; i++)
            if (m_pend[i] && (p < 0 || m_id[i] < m_id[p])) p = i;
        return p;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pend = '0; exp_done = '0; exp_fail = '0; exp_werr = 0;
            fl_v = 0; lat = 0; act_prev = 0; fl = 0;
            for (int i = 0; i < NMB; i++) begin
                m_id[i] = '0; m_data[i] = '0; m_retry[i] = 0;
            end
        end else begin
            exp_done = '0; exp_fail = '0; exp_werr = 0;
            for (int i = 0; i < NMB; i++) begin
                if (mb_abort[i]) begin
                    if (mb_wr[i]) exp_werr = 1;
                    if (fl_v && fl == i) lat = 1;
                    else begin
                        if (m_pend[i]) exp_fail[i] = 1;
                        m_pend[i] = 0;
                    end
                end else if (mb_wr[i]) begin
                    if (fl_v && fl == i) exp_werr = 1;
                    else begin
                        m_id[i] = mb_wr_id; m_data[i] = mb_wr_data;
                        m_pend[i] = 1; m_retry[i] = 0;
                    end
                end
            end
            if (fl_v && frame_done) begin
                m_pend[fl] = 0; exp_done[fl] = 1; fl_v = 0;
            end else if (fl_v && arb_lost) begin
                if (m_retry[fl] < 15) m_retry[fl]++;
                if (lat || m_retry[fl] == RMAX) begin
                    m_pend[fl] = 0; exp_fail[fl] = 1;
                end
                fl_v = 0;
            end
            if (m_to && baud_tick && pick() >= 0) begin
                exp_fail[pick()] = 1;
                m_pend[pick()] = 0;
            end
            if (tx_active && !act_prev) begin
                fl_v = 1; fl = pick(); lat = 0;
            end
            act_prev = tx_active;
        end
    end

    logic [3:0] seen_done, seen_fail;
    logic       seen_werr;

    always @(negedge clk) begin
        check("pending", mb_pending, m_pend);
        check("done_pulse", mb_done, exp_done);
        check("fail_pulse", mb_fail, exp_fail);
        check("wr_err", wr_err, exp_werr);
        if (tx_send) begin
            check("launch_cur", cur_mb, pick());
            if (pick() >= 0) begin
                check("launch_addr", tx_address, m_id[pick()]);
                check("launch_data", tx_data, m_data[pick()]);
            end
        end
        if (fl_v) begin
            check("flight_cur", cur_mb, fl);
            check("flight_addr", tx_address, m_id[fl]);
            check("flight_data", tx_data, m_data[fl]);
        end
        seen_done |= mb_done;
        seen_fail |= mb_fail;
        seen_werr |= wr_err;
    end

    task automatic cyc1();
        @(posedge clk); #1;
    endtask

    task automatic clear_seen();
        seen_done = '0; seen_fail = '0; seen_werr = 0;
    endtask

    task automatic write(input logic [3:0] m, input logic [10:0] id,
                         input logic [63:0] d);
        mb_wr = m; mb_wr_id = id; mb_wr_data = d;
        cyc1();
        mb_wr = '0;
    endtask

    task automatic abort(input logic [3:0] m);
        mb_abort = m;
        cyc1();
        mb_abort = '0;
    endtask

    task automatic wait_send(output int n, output int idx);
        n = 0;
        while (tx_send !== 1'b1 && n < 40) begin
            cyc1(); n++;
        end
        check("send_seen", tx_send, 1);
        idx = int'(cur_mb);
    endtask

    task automatic engine_start();
        tx_active = 1;
        cyc1();
    endtask

    task automatic finish(input bit lost);
        if (lost) arb_lost = 1;
        else      frame_done = 1;
        cyc1();
        arb_lost = 0; frame_done = 0; tx_active = 0;
    endtask

    task automatic pulse_tick();
        baud_tick = 1; cyc1(); baud_tick = 0; cyc1();
    endtask

    task automatic ifs(output int n);
        n = 0;
        tx_active = 0;
        while (n < 40) begin
            baud_tick = 1; cyc1(); baud_tick = 0; n++;
            if (!busy) break;
            cyc1();
        end
        check("ifs_idle", busy, 0);
    endtask

    task automatic send_one(input bit lost, output int idx);
        int n;
        wait_send(n, idx);
        engine_start();
        finish(lost);
        ifs(n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, idx, launches;
        int q[$];
        m_to = 0;
        clear_seen();
        repeat (2) cyc1();
        check("rst_send", tx_send, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", mb_pending, 0);
        check("rst_addr", tx_address, 0);
        check("rst_data", tx_data, 0);
        check("rst_cur", cur_mb, 0);
        rst = 1;
        cyc1();

        // single frame
        clear_seen();
        write(4'b0001, 11'h123, 64'hDEADBEEF_00000001);
        wait_send(n, idx);
        check("t1_latency", n + 1, 3);
        check("t1_addr", tx_address, 11'h123);
        check("t1_data", tx_data, 64'hDEADBEEF_00000001);
        engine_start();
        check("t1_send_drop", tx_send, 0);
        finish(0);
        ifs(n);
        check("t1_done", seen_done, 4'b0001);
        check("t1_pend", mb_pending, 4'b0000);
        check("t1_ifs_ticks", n, 3);

        // priority, tie on ID goes to lower index
        clear_seen();
        q.delete();
        write(4'b0001, 11'h400, 64'hA0);
        write(4'b1100, 11'h010, 64'hB0);
        for (int k = 0; k < 3; k++) begin
            send_one(0, idx);
            q.push_back(idx);
        end
        check("t2_order0", q[0], 2);
        check("t2_order1", q[1], 3);
        check("t2_order2", q[2], 0);
        check("t2_done", seen_done, 4'b1101);

        // retry limit
        clear_seen();
        write(4'b0010, 11'h055, 64'h55);
        launches = 0;
        for (int k = 0; k < 10 && mb_pending[1]; k++) begin
            send_one(1, idx);
            launches++;
        end
        check("t3_launches", launches, 7);
        check("t3_fail", seen_fail, 4'b0010);
        check("t3_pend", mb_pending, 4'b0000);

        clear_seen();
        write(4'b0010, 11'h055, 64'h56);
        for (int k = 1; k <= 3; k++) send_one(k < 3, idx);
        check("t3b_done", seen_done, 4'b0010);
        check("t3b_nofail", seen_fail, 4'b0000);

        // preemption after arbitration loss
        clear_seen();
        write(4'b0001, 11'h300, 64'h300);
        wait_send(n, idx);
        engine_start();
        write(4'b0010, 11'h001, 64'h001);
        finish(1);
        ifs(n);
        wait_send(n, idx);
        check("t4_cur", idx, 1);
        check("t4_addr", tx_address, 11'h001);
        engine_start(); finish(0); ifs(n);
        send_one(0, idx);
        check("t4_second", idx, 0);
        check("t4_done", seen_done, 4'b0011);

        // abort / write conflicts
        clear_seen();
        write(4'b0001, 11'h100, 64'h1111);
        wait_send(n, idx);
        engine_start();
        write(4'b0100, 11'h200, 64'h2222);
        abort(4'b0100);
        check("t5_abort_fail", mb_fail, 4'b0100);
        check("t5_abort_pend", mb_pending, 4'b0001);
        write(4'b0001, 11'h050, 64'hBAD);
        check("t5_werr", wr_err, 1);
        check("t5_data_kept", tx_data, 64'h1111);
        seen_werr = 0;
        mb_abort = 4'b1000;
        write(4'b1000, 11'h0AB, 64'hAB);
        mb_abort = '0;
        check("t5_wa_werr", wr_err, 1);
        check("t5_wa_pend", mb_pending, 4'b0001);
        abort(4'b0001);
        finish(0);
        ifs(n);
        check("t5_done", seen_done, 4'b0001);
        check("t5_fails", seen_fail, 4'b0100);

        // start timeout
        clear_seen();
        write(4'b0010, 11'h077, 64'h77);
        wait_send(n, idx);
        repeat (15) pulse_tick();
        check("t6_still_send", tx_send, 1);
        check("t6_no_fail_yet", seen_fail, 4'b0000);
        m_to = 1; baud_tick = 1;
        cyc1();
        m_to = 0; baud_tick = 0;
        check("t6_fail", mb_fail, 4'b0010);
        check("t6_send_off", tx_send, 0);
        ifs(n);
        check("t6_pend", mb_pending, 4'b0000);

        // asynchronous reset mid-frame
        clear_seen();
        write(4'b0001, 11'h0AA, 64'hAA);
        wait_send(n, idx);
        engine_start();
        #2 rst = 0;
        #1;
        check("t7_send", tx_send, 0);
        check("t7_pend", mb_pending, 4'b0000);
        check("t7_busy", busy, 0);
        check("t7_pulses", {mb_done, mb_fail, wr_err}, 0);
        tx_active = 0;
        cyc1(); cyc1();
        rst = 1;
        cyc1(); cyc1();
        check("t7_idle", busy, 0);
        check("t7_nodone", seen_done, 4'b0000);
        check("t7_nofail", seen_fail, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
Transmit mailbox scheduler in front of the CAN TX engine. Holds NUM_MB pending frames (11-bit ID, 64-bit data) and always launches the highest-priority one, meaning the lowest ID. It sequences the engine through launch, frame and interframe spacing, and handles retry after arbitration loss, abort and completion reporting per mailbox.

Parameters:
NUM_MB, 4, number of transmit mailboxes (2..8)
RETRY_MAX, 7, arbitration losses tolerated per mailbox before failure (1..15)
IFS_BITS, 3, baud ticks of interframe space after every frame or loss
START_TIMEOUT, 16, baud ticks allowed between tx_send assert and tx_active

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
baud_tick  in  1  one-clk pulse per CAN bit time
mb_wr  in  NUM_MB  load strobe per mailbox (one-hot or multiple)
mb_wr_id  in  11  ID for loaded mailbox(es)
mb_wr_data  in  64  data for loaded mailbox(es)
mb_abort  in  NUM_MB  cancel request per mailbox
tx_active  in  1  TX engine inside a frame
frame_done  in  1  one-clk pulse: frame transmitted, EOF complete
arb_lost  in  1  one-clk pulse: engine lost arbitration, back to idle
tx_send  out  1  launch request to TX engine
tx_address  out  11  ID of selected mailbox
tx_data  out  64  data of selected mailbox
cur_mb  out  3  index of selected mailbox
mb_pending  out  NUM_MB  mailbox holds an unsent frame
mb_done  out  NUM_MB  one-clk pulse: mailbox sent
mb_fail  out  NUM_MB  one-clk pulse: mailbox dropped (retry limit, abort or start timeout)
wr_err  out  1  one-clk pulse: write to in-flight mailbox rejected
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, async): all outputs 0. Mailbox storage, retry counters and FSM cleared; FSM=IDLE.
- Write: mb_wr[i] stores the ID and data and sets pending[i] on the next clk. Retry counter[i] clears.
- Write rejection: if i is in flight (state LAUNCH or BUSY, cur_mb=i), the write is ignored and wr_err pulses.
- Write plus abort on the same index in the same cycle: abort wins, the write is dropped, wr_err pulses.
- Abort, mailbox not in flight: pending[i] clears next clk, mb_fail[i] pulses if it was pending; no pulse if it was not pending.
- Abort, mailbox in flight: the abort is latched. It takes effect only on arb_lost or timeout (fail pulse). On frame_done, mb_done wins and the latched abort is discarded.
- FSM states: IDLE, SELECT, LAUNCH, BUSY, IFS.
- IDLE: if any pending and tx_active=0, go to SELECT.
- SELECT (1 clk): pick the pending index with the minimum ID; ties go to the lowest index. Register tx_address, tx_data and cur_mb. Go to LAUNCH.
- LAUNCH: tx_send=1.
  - tx_active seen: go to BUSY, drop tx_send.
  - START_TIMEOUT baud ticks with no tx_active: pending clears, mb_fail pulses, go to IFS.
- BUSY: tx_send=0.
  - frame_done: pending[cur_mb] clears, mb_done pulses, go to IFS.
  - arb_lost: retry[cur_mb]++. If the new value equals RETRY_MAX, pending clears and mb_fail pulses; otherwise pending stays set. Go to IFS.
  - frame_done and arb_lost together: treat as frame_done.
- IFS: wait until tx_active=0, then count IFS_BITS baud ticks, then go to IDLE. A re-selection follows, so a higher-priority mailbox written during the frame wins the next slot.
- Launch latency: mailbox write to tx_send = 3 clks from IDLE (write, IDLE, SELECT).
- tx_address and tx_data hold stable from SELECT until the next SELECT.
- Retry counters are 4 bits wide and saturate; a mailbox reload clears its counter.
- Pulse outputs are exactly one clk wide and registered.

Test Plan:
- Single frame: mb_wr[0], ID=0x123, data=0xDEADBEEF_00000001. Engine raises tx_active, then frame_done → tx_send high on the 3rd clk after the write, tx_address=0x123, mb_done[0] pulse, pending=0000, busy returns 0 after 3 baud ticks with tx_active low.
- Priority: load mb0 ID=0x400, mb2 ID=0x010, mb3 ID=0x010 together → launch order mb2, mb3, mb0 (cur_mb 2,3,0); three mb_done pulses in that order.
- Retry limit: mb1 ID=0x055, arb_lost on every attempt → exactly 7 launches, mb_fail[1] on the 7th loss, pending[1]=0. Repeat with frame_done on the 3rd attempt → mb_done[1], no fail.
- Preemption after loss: mb0 ID=0x300 in flight; write mb1 ID=0x001 during BUSY, then arb_lost → next SELECT picks cur_mb=1, tx_address=0x001; mb0 still pending and sent after it.
- Abort/write conflicts: abort idle pending mb2 → mb_fail[2], pending cleared. Write to in-flight mb0 → wr_err, tx_data unchanged. Abort in-flight mb0 then frame_done → mb_done[0], no fail.
- Timeout and reset: tx_active never asserts → mb_fail after 16 baud ticks. Separately, rst low mid-BUSY → tx_send=0, pending=0, busy=0 immediately, with no pulses.
